// File: rtl/flash_ctrl.sv
// flash_ctrl: StrataFlash word read/program controller; req/op/addr/wdata in, rdata/done/busy/error out, registered flash pins
module flash_ctrl #(
  parameter int T_WP = 4,
  parameter int T_ACC = 6,
  parameter int POLL_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        op,
  input  logic [22:1] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        error,
  output logic [22:1] flash_addr,
  inout  wire  [15:0] flash_data,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic        flash_byte_n,
  output logic        flash_rp_n,
  output logic        flash_vpen
);
  localparam int WMAX = T_WP > T_ACC ? T_WP : T_ACC;
  localparam int CW = $clog2(WMAX + 1);
  typedef enum logic [3:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACC, R_LATCH, POLL_GAP, DONE, GAP} state_t;
  typedef enum logic [2:0] {PH_RCMD, PH_RARR, PH_SETUP, PH_DATA, PH_SCMD, PH_POLL, PH_FIN} phase_t;
  state_t state, nxt;
  phase_t phase, ph_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] pcnt, pc_n, wd_q, wd_n, rd_n, dout, dout_n;
  logic [22:1] fa_n;
  logic err_n, drv, drv_n, ce_nx, oe_nx, we_nx, done_n, busy_n;
  assign flash_data = drv ? dout : 16'hzzzz;
  assign flash_byte_n = 1'b1;
  assign flash_vpen = 1'b1;
  always_comb begin
    nxt = state;
    ph_n = phase;
    wd_n = wd_q;
    fa_n = flash_addr;
    pc_n = pcnt;
    err_n = error;
    rd_n = rdata;
    case (state)
      IDLE: if (req) begin
        nxt = W_SETUP;
        ph_n = op ? PH_SETUP : PH_RCMD;
        wd_n = wdata;
        fa_n = addr;
        pc_n = '0;
        err_n = 1'b0;
      end
      W_SETUP: nxt = W_PULSE;
      W_PULSE: nxt = cnt == '0 ? W_HOLD : W_PULSE;
      W_HOLD: begin
        nxt = phase == PH_FIN ? DONE : (phase == PH_RCMD || phase == PH_SCMD) ? R_ACC : W_SETUP;
        ph_n = phase == PH_RCMD ? PH_RARR : phase == PH_SETUP ? PH_DATA :
               phase == PH_DATA ? PH_SCMD : phase == PH_SCMD ? PH_POLL : phase;
      end
      R_ACC: nxt = cnt == '0 ? R_LATCH : R_ACC;
      R_LATCH: begin
        rd_n = flash_data;
        if (phase == PH_RARR) nxt = DONE;
        else begin
          pc_n = pcnt == 16'(POLL_MAX) ? pcnt : pcnt + 16'd1;
          if (flash_data[7]) begin
            nxt = W_SETUP;
            ph_n = PH_FIN;
            err_n = flash_data[4] | flash_data[3] | flash_data[1];
          end else if (int'(pcnt) + 1 >= POLL_MAX) begin
            nxt = DONE;
            err_n = 1'b1;
          end else nxt = POLL_GAP;
        end
      end
      POLL_GAP: nxt = R_ACC;
      DONE: nxt = GAP;
      GAP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    cnt_n = nxt != state ? CW'(nxt == W_PULSE ? T_WP - 1 : T_ACC - 1) : cnt - 1'b1;
    ce_nx = nxt == IDLE || nxt == DONE || nxt == GAP;
    oe_nx = !(nxt == R_ACC || nxt == R_LATCH);
    we_nx = nxt != W_PULSE;
    drv_n = nxt == W_SETUP || nxt == W_PULSE || nxt == W_HOLD;
    dout_n = ph_n == PH_DATA ? wd_n : ph_n == PH_SETUP ? 16'h0040 : ph_n == PH_SCMD ? 16'h0070 : 16'h00FF;
    done_n = nxt == DONE;
    busy_n = !(nxt == IDLE || nxt == GAP);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      phase <= PH_RCMD;
      cnt <= '0;
      pcnt <= '0;
      wd_q <= '0;
      flash_addr <= '0;
      error <= 1'b0;
      rdata <= '0;
      flash_ce_n <= 1'b1;
      flash_oe_n <= 1'b1;
      flash_we_n <= 1'b1;
      drv <= 1'b0;
      dout <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      flash_rp_n <= 1'b0;
    end else begin
      state <= nxt;
      phase <= ph_n;
      cnt <= cnt_n;
      pcnt <= pc_n;
      wd_q <= wd_n;
      flash_addr <= fa_n;
      error <= err_n;
      rdata <= rd_n;
      flash_ce_n <= ce_nx;
      flash_oe_n <= oe_nx;
      flash_we_n <= we_nx;
      drv <= drv_n;
      dout <= dout_n;
      done <= done_n;
      busy <= busy_n;
      flash_rp_n <= 1'b1;
    end
  end
endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: flash bus model plus table, random and corner-case checks of flash_ctrl
module tb_flash_ctrl;
  localparam int TWP = 4, TACC = 6, PM = 8;
  typedef struct {
    logic op;
    logic [21:0] addr;
    logic [15:0] wdata;
    int polls;
    logic [15:0] status;
    logic [15:0] rdata;
    logic err;
    int lat;
  } vec_t;
  logic clk = 0, rst = 0, req = 0, op = 0;
  logic [22:1] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic done, busy, error;
  logic [22:1] flash_addr;
  wire [15:0] flash_data;
  logic ce_n, oe_n, we_n, byte_n, rp_n, vpen;
  int errors = 0, checks = 0, conflicts = 0;
  always #5 clk = ~clk;
  flash_ctrl #(.T_WP(TWP), .T_ACC(TACC), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .error(error),
    .flash_addr(flash_addr), .flash_data(flash_data),
    .flash_ce_n(ce_n), .flash_oe_n(oe_n), .flash_we_n(we_n),
    .flash_byte_n(byte_n), .flash_rp_n(rp_n), .flash_vpen(vpen)
  );
  function automatic logic [15:0] word(input logic [21:0] a);
    return a == 22'h123 ? 16'hA5C3 : (a[15:0] * 16'd40503) ^ {10'd0, a[21:16]};
  endfunction
  logic status_mode = 0, prog_next = 0, pend = 0, oe_q = 1;
  int polls_left = 0, cfg_polls = 0, sreads = 0, areads = 0;
  logic [15:0] cfg_status = 0, wd = 0, mout;
  logic [21:0] wa = 0;
  logic [37:0] wlog[$];
  assign mout = status_mode ? (polls_left > 0 ? 16'h0000 : cfg_status) : word(flash_addr);
  assign flash_data = (!oe_n && !ce_n) ? mout : 16'hzzzz;
  always @(negedge clk) begin
    oe_q <= oe_n;
    if (!oe_n && !we_n) conflicts <= conflicts + 1;
    if (!rp_n) begin
      status_mode <= 0;
      prog_next <= 0;
      pend <= 0;
      polls_left <= 0;
    end else begin
      if (!ce_n && !we_n) begin
        pend <= 1;
        wa <= flash_addr;
        wd <= flash_data;
      end else if (pend) begin
        pend <= 0;
        wlog.push_back({wa, wd});
        if (prog_next) begin
          prog_next <= 0;
          status_mode <= 1;
          polls_left <= cfg_polls;
        end else if (wd == 16'h00FF) status_mode <= 0;
        else if (wd == 16'h0070) status_mode <= 1;
        else if (wd == 16'h0040) prog_next <= 1;
      end
      if (!oe_q && oe_n) begin
        if (status_mode) begin
          sreads <= sreads + 1;
          if (polls_left > 0) polls_left <= polls_left - 1;
        end else areads <= areads + 1;
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t model(input logic o, input logic [21:0] a, input logic [15:0] d, input int p, input logic [15:0] s);
    vec_t v;
    bit ok;
    int n;
    v.op = o; v.addr = a; v.wdata = d; v.polls = p; v.status = s;
    ok = p < PM;
    n = ok ? p + 1 : PM;
    if (!o) begin
      v.rdata = word(a);
      v.err = 0;
      v.lat = TWP + TACC + 4;
    end else begin
      v.rdata = ok ? s : 16'h0000;
      v.err = ok ? (s[4] | s[3] | s[1]) : 1'b1;
      v.lat = 3 * (TWP + 2) + n * (TACC + 1) + (n - 1) + (ok ? TWP + 2 : 0) + 1;
    end
    return v;
  endfunction
  task automatic run_op(input vec_t v, input string nm);
    int k, w0, s0, a0, n;
    logic [37:0] exp[$];
    cfg_polls = v.polls;
    cfg_status = v.status;
    w0 = wlog.size();
    s0 = sreads;
    a0 = areads;
    op = v.op; addr = v.addr; wdata = v.wdata; req = 1;
    @(negedge clk);
    k = 1;
    req = 0;
    op = ~op; addr = ~addr; wdata = ~wdata;
    chk({nm, "/busy"}, busy, 1);
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "/lat"}, k, v.lat);
    chk({nm, "/rdata"}, rdata, v.rdata);
    chk({nm, "/error"}, error, v.err);
    @(negedge clk);
    chk({nm, "/gap"}, {done, busy}, 2'b00);
    n = v.op ? (v.polls < PM ? v.polls + 1 : PM) : 1;
    if (!v.op) exp = '{{v.addr, 16'h00FF}};
    else begin
      exp = '{{v.addr, 16'h0040}, {v.addr, v.wdata}, {v.addr, 16'h0070}};
      if (v.polls < PM) exp.push_back({v.addr, 16'h00FF});
    end
    chk({nm, "/nwr"}, wlog.size() - w0, exp.size());
    foreach (exp[i]) if (w0 + i < wlog.size()) chk({nm, "/wr"}, wlog[w0 + i], exp[i]);
    chk({nm, "/sreads"}, sreads - s0, v.op ? n : 0);
    chk({nm, "/areads"}, areads - a0, v.op ? 0 : 1);
    @(negedge clk);
  endtask
  vec_t tbl[7];
  initial begin
    int k;
    bit stuck;
    tbl[0] = '{0, 22'h000123, 16'h0000, 0, 16'h0000, 16'hA5C3, 0, 14};
    tbl[1] = '{1, 22'h000400, 16'h1234, 3, 16'h0080, 16'h0080, 0, 56};
    tbl[2] = '{1, 22'h000007, 16'hBEEF, 0, 16'h0090, 16'h0090, 1, 32};
    tbl[3] = '{1, 22'h000055, 16'h0000, 100, 16'h0080, 16'h0000, 1, 82};
    tbl[4] = '{1, 22'h3FFFFF, 16'hFFFF, 7, 16'h0082, 16'h0082, 1, 88};
    tbl[5] = '{1, 22'h000002, 16'h0001, 1, 16'h0088, 16'h0088, 1, 40};
    tbl[6] = '{0, 22'h3FFFFF, 16'h0000, 0, 16'h0000, 16'h61F6, 0, 14};
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst/strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("rst/rp_n", rp_n, 0);
    chk("rst/flags", {done, busy, error}, 3'b000);
    chk("rst/rdata", rdata, 0);
    chk("rst/faddr", flash_addr, 0);
    chk("rst/byte_vpen", {byte_n, vpen}, 2'b11);
    rst = 1;
    @(negedge clk);
    chk("rst/rp_n_rel", rp_n, 1);
    @(negedge clk);
    foreach (tbl[i]) run_op(tbl[i], $sformatf("tbl%0d", i));
    for (int i = 0; i < 20; i++) begin
      logic o;
      o = 1'($urandom);
      run_op(model(o, 22'($urandom), 16'($urandom), int'($urandom_range(0, 10)), 16'($urandom) | 16'h0080),
             $sformatf("rnd%0d", i));
    end
    cfg_polls = 3;
    cfg_status = 16'h0080;
    op = 1; addr = 22'h000400; wdata = 16'h1234; req = 1;
    @(negedge clk);
    req = 0;
    k = 0;
    while (we_n && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid/pulse", we_n, 0);
    rst = 0;
    @(negedge clk);
    chk("rstmid/strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("rstmid/flags", {done, busy, error, rp_n}, 4'b0000);
    k = 0;
    repeat (3) begin
      @(negedge clk);
      k += int'(done);
    end
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      k += int'(done);
    end
    chk("rstmid/nodone", k, 0);
    run_op(tbl[0], "after_rst");
    op = 0; addr = 22'h1; req = 1;
    stuck = 0;
    for (int a = 1; a <= 22'h21A && !stuck; a++) begin
      k = (a == 1) ? 0 : 1;
      while (!done && k < 100) begin
        @(negedge clk);
        k++;
      end
      stuck = !done;
      chk($sformatf("b2b%0h/period", a), k, a == 1 ? 14 : 16);
      chk($sformatf("b2b%0h/rdata", a), rdata, word(22'(a)));
      chk($sformatf("b2b%0h/wr", a), wlog[$], {22'(a), 16'h00FF});
      @(negedge clk);
      addr = 22'(a + 1);
      if (a == 22'h21A) req = 0;
    end
    req = 0;
    repeat (3) @(negedge clk);
    chk("b2b/idle", {busy, done}, 2'b00);
    chk("oe_we_overlap", conflicts, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
